// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns (active-low, bit6=a..bit0=g), FSM states and the blank BCD code
package seven_seg_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_RELEASE} state_t;
endpackage

// File: rtl/seven_seg_pattern_decode.sv
// seven_seg_pattern_decode: maps a 7-bit active-low segment pattern to BCD, flagging digit/blank
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       blank
);
  always_comb begin
    bcd = seg == SEG_0 ? 4'd0 : seg == SEG_1 ? 4'd1 : seg == SEG_2 ? 4'd2 :
          seg == SEG_3 ? 4'd3 : seg == SEG_4 ? 4'd4 : seg == SEG_5 ? 4'd5 :
          seg == SEG_6 ? 4'd6 : seg == SEG_7 ? 4'd7 : seg == SEG_8 ? 4'd8 :
          seg == SEG_9 ? 4'd9 : BCD_BLANK;
    blank = seg == SEG_BLANK;
    valid = bcd != BCD_BLANK;
  end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: recovers filtered per-digit BCD from a multiplexed active-low
// seven-segment bus, with blank/valid flags, invalid-pattern errors and frame completion.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int SETTLE       = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   an_in,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   digit_valid,
  output logic [NDIG-1:0]   digit_blank,
  output logic              err,
  output logic [2:0]        err_digit,
  output logic              frame_done
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam int IW = $clog2(NDIG);
  logic [6:0] seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;
  logic [NDIG-1:0] an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_p_q, an_p_d, an_hold_q, an_hold_d;
  logic [NDIG-1:0] seen_q, seen_d, seen_nx, valid_q, valid_d, blank_q, blank_d, sel_oh;
  logic [NDIG-1:0][3:0] cand_q, cand_d, bcd_q, bcd_d;
  logic [NDIG-1:0][MW-1:0] mcnt_q, mcnt_d;
  logic [MW-1:0] mc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] sel_idx;
  logic [3:0] dec_bcd;
  logic [2:0] err_digit_q, err_digit_d;
  logic err_q, err_d, frame_q, frame_d, one_hot, changed, dec_valid, dec_blank;
  state_t state_q, state_d;
  // Capture uses the previous-cycle synced values: those are the ones proven stable.
  seven_seg_pattern_decode u_dec (.seg(seg_p_q), .bcd(dec_bcd), .valid(dec_valid), .blank(dec_blank));
  assign one_hot = $onehot(~an_s2_q);
  assign changed = an_s2_q != an_p_q || seg_s2_q != seg_p_q;
  assign sel_oh  = ~an_p_q;
  assign bcd_out = bcd_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign err = err_q;
  assign err_digit = err_digit_q;
  assign frame_done = frame_q;
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) if (sel_oh[i]) sel_idx = IW'(i);
  end
  always_comb begin
    seg_s1_d = seg_in;
    seg_s2_d = seg_s1_q;
    seg_p_d  = seg_s2_q;
    an_s1_d  = an_in;
    an_s2_d  = an_s1_q;
    an_p_d   = an_s2_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    an_hold_d = an_hold_q;
    case (state_q)
      S_IDLE: begin
        state_d = one_hot ? S_SETTLE : S_IDLE;
        cnt_d   = CW'(1);
      end
      S_SETTLE: begin
        state_d = !one_hot ? S_IDLE : (!changed && cnt_q == CW'(SETTLE)) ? S_CAPTURE : S_SETTLE;
        cnt_d   = changed ? CW'(1) : cnt_q + CW'(1);
      end
      S_CAPTURE: begin
        state_d   = S_RELEASE;
        an_hold_d = an_p_q;
      end
      default: begin
        state_d = an_s2_q == an_hold_q ? S_RELEASE : one_hot ? S_SETTLE : S_IDLE;
        cnt_d   = CW'(1);
      end
    endcase
  end
  always_comb begin
    cand_d = cand_q;
    mcnt_d = mcnt_q;
    bcd_d = bcd_q;
    valid_d = valid_q;
    blank_d = blank_q;
    err_d = 1'b0;
    err_digit_d = err_digit_q;
    frame_d = 1'b0;
    seen_nx = seen_q | sel_oh;
    seen_d = seen_q;
    mc = cand_q[sel_idx] != dec_bcd ? MW'(1) :
         mcnt_q[sel_idx] == MW'(STABLE_SCANS) ? mcnt_q[sel_idx] : mcnt_q[sel_idx] + MW'(1);
    if (state_q == S_CAPTURE) begin
      frame_d = &seen_nx;
      seen_d = frame_d ? '0 : seen_nx;
      if (!dec_valid && !dec_blank) begin
        err_d = 1'b1;
        err_digit_d = 3'(sel_idx);
      end else begin
        cand_d[sel_idx] = dec_bcd;
        mcnt_d[sel_idx] = mc;
        if (mc == MW'(STABLE_SCANS)) begin
          bcd_d[sel_idx] = dec_bcd;
          valid_d[sel_idx] = dec_valid;
          blank_d[sel_idx] = dec_blank;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      seg_p_q <= '1;
      an_s1_q <= '1;
      an_s2_q <= '1;
      an_p_q <= '1;
      an_hold_q <= '1;
      state_q <= S_IDLE;
      cnt_q <= '0;
      cand_q <= '1;
      mcnt_q <= '0;
      bcd_q <= '1;
      valid_q <= '0;
      blank_q <= '0;
      seen_q <= '0;
      err_q <= 1'b0;
      err_digit_q <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      seg_p_q <= seg_p_d;
      an_s1_q <= an_s1_d;
      an_s2_q <= an_s2_d;
      an_p_q <= an_p_d;
      an_hold_q <= an_hold_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      cand_q <= cand_d;
      mcnt_q <= mcnt_d;
      bcd_q <= bcd_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      seen_q <= seen_d;
      err_q <= err_d;
      err_digit_q <= err_digit_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed scans of a 4-digit active-low display bus with
// hand-computed expectations for filtering, errors, blanking, settle rejection and reset.
module tb_seven_seg_scan_decoder;
  localparam int NDIG = 4;
  localparam int SETTLE = 4;
  localparam logic [6:0] P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110, P4 = 7'b1001100;
  localparam logic [6:0] P8 = 7'b0000000, PBL = 7'b1111111, BAD = 7'b1111110, BAD2 = 7'b1111101;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg_in = '1;
  logic [NDIG-1:0] an_in = '1;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0] digit_valid, digit_blank;
  logic err, frame_done;
  logic [2:0] err_digit;
  int tests = 0, fails = 0, n_err = 0, n_frame = 0;
  seven_seg_scan_decoder #(.NDIG(NDIG), .SETTLE(SETTLE), .STABLE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .bcd_out(bcd_out),
    .digit_valid(digit_valid), .digit_blank(digit_blank), .err(err),
    .err_digit(err_digit), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (err) n_err++;
    if (frame_done) n_frame++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic show(input int d, input logic [6:0] s, input int n);
    an_in = ~(NDIG'(1) << d);
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    an_in = '1;
    seg_in = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    show(0, s0, 10);
    show(1, s1, 10);
    show(2, s2, 10);
    show(3, s3, 10);
    idle(10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'(bcd_out), 32'hFFFF);
    check("rst_valid", 32'(digit_valid), 0);
    check("rst_blank", 32'(digit_blank), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_digit", 32'(err_digit), 0);
    check("rst_frame", 32'(frame_done), 0);
    rst = 1'b0;
    idle(3);
    scan(P1, P2, P3, P4);
    check("scan1_bcd", 32'(bcd_out), 32'hFFFF);
    check("scan1_valid", 32'(digit_valid), 0);
    check("scan1_frames", n_frame, 1);
    scan(P1, P2, P3, P4);
    check("scan2_bcd", 32'(bcd_out), 32'h1234);
    check("scan2_valid", 32'(digit_valid), 32'hF);
    check("scan2_blank", 32'(digit_blank), 0);
    check("scan2_frames", n_frame, 2);
    scan(P1, P8, P3, P4);
    scan(P1, P1, P3, P4);
    scan(P1, P8, P3, P4);
    scan(P1, P1, P3, P4);
    check("alt_bcd", 32'(bcd_out), 32'h1234);
    check("alt_valid", 32'(digit_valid), 32'hF);
    check("alt_frames", n_frame, 6);
    show(1, BAD, 10);
    idle(10);
    check("bad_err_count", n_err, 1);
    check("bad_err_digit", 32'(err_digit), 1);
    check("bad_bcd", 32'(bcd_out), 32'h1234);
    scan(PBL, P2, P3, P4);
    check("blank1_bcd", 32'(bcd_out), 32'h1234);
    scan(PBL, P2, P3, P4);
    check("blank2_bcd", 32'(bcd_out), 32'hF234);
    check("blank2_valid", 32'(digit_valid), 32'h7);
    check("blank2_blank", 32'(digit_blank), 32'h8);
    show(0, BAD, SETTLE);
    idle(10);
    check("short_strobe", n_err, 1);
    show(0, BAD, 3);
    show(0, BAD2, 3);
    idle(10);
    check("seg_toggle", n_err, 1);
    show(0, BAD, SETTLE + 1);
    idle(10);
    check("min_strobe", n_err, 2);
    check("min_strobe_digit", 32'(err_digit), 0);
    show(1, BAD, 3);
    #3 rst = 1'b1;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'hFFFF);
    check("midrst_valid", 32'(digit_valid), 0);
    check("midrst_blank", 32'(digit_blank), 0);
    check("midrst_err_digit", 32'(err_digit), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("relat_early", 32'(err), 0);
    @(posedge clk);
    #1;
    check("relat_err", 32'(err), 1);
    check("relat_err_digit", 32'(err_digit), 1);
    idle(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
